shift_sequencer: RTL



---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_cmd_buf.sv | 33 +++
 rtl/shift_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: select codes, FSM states and command record shared by the shift sequencer.
package shift_pkg;
    localparam logic [2:0] SEL_HOLD = 3'd0;
    localparam logic [2:0] SEL_ROTR = 3'd1;
    localparam logic [2:0] SEL_ROTL = 3'd2;
    localparam logic [2:0] SEL_SHR  = 3'd3;
    localparam logic [2:0] SEL_SHL  = 3'd4;
    localparam logic [2:0] SEL_ASR  = 3'd5;
    localparam logic [2:0] SEL_SHL2 = 3'd6;
    localparam logic [2:0] SEL_LOAD = 3'd7;
    localparam int CNT_MAX_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} seq_state_e;

    typedef struct packed {
        logic                 load_en;
        logic [0:3]           load_val;
        logic [2:0]           op;
        logic [CNT_MAX_W-1:0] count;
    } shift_cmd_t;

    // A captured LOAD opcode must never repeat a parallel load during RUN.
    function automatic logic [2:0] sel_for(seq_state_e st, logic [2:0] op);
        return st == ST_LOAD ? SEL_LOAD : (st == ST_RUN && op != SEL_LOAD) ? op : SEL_HOLD;
    endfunction
endpackage

// File: rtl/shift_cmd_buf.sv
// shift_cmd_buf: one-entry command holding slot with valid flag, filled while the sequencer is busy.
module shift_cmd_buf
    import shift_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       push_i,
    input  shift_cmd_t cmd_i,
    input  logic       pop_i,
    output logic       valid_o,
    output shift_cmd_t cmd_o
);
    logic       valid_q, valid_d;
    shift_cmd_t cmd_q, cmd_d;

    always_comb begin
        valid_d = (push_i && !valid_q) ? 1'b1 : pop_i ? 1'b0 : valid_q;
        cmd_d   = (push_i && !valid_q) ? cmd_i : cmd_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
        end
    end

    assign valid_o = valid_q;
    assign cmd_o   = cmd_q;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: issues load/shift/hold select cycles to a 4-bit universal shift register.
// Define SHIFT_SEQ_CMDBUF_EN to add a one-entry command buffer accepted while busy.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             LoadEn,
    input  logic [0:3]       LoadVal,
    input  logic [2:0]       Op,
    input  logic [CNT_W-1:0] Count,
    output logic [2:0]       S,
    output logic [0:3]       L,
    output logic             Busy,
    output logic             Done
);
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:3]       l_q, l_d;
    logic [2:0]       op_q, op_d, s_q;
    logic             busy_q, done_q;
    logic             pend_v;
    shift_cmd_t       in_cmd, pend_cmd, src;

    assign in_cmd = '{LoadEn, LoadVal, Op, CNT_MAX_W'(Count)};

`ifdef SHIFT_SEQ_CMDBUF_EN
    shift_cmd_buf u_buf (
        .Clock   (Clock),
        .Reset   (Reset),
        .push_i  (Start && busy_q && !pend_v),
        .cmd_i   (in_cmd),
        .pop_i   (pend_v && (state_q == ST_IDLE || state_q == ST_DONE)),
        .valid_o (pend_v),
        .cmd_o   (pend_cmd)
    );
`else
    assign pend_v   = 1'b0;
    assign pend_cmd = '0;
`endif

    always_comb begin
        src     = pend_v ? pend_cmd : in_cmd;
        state_d = state_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        op_d    = op_q;
        if ((state_q == ST_IDLE && (Start || pend_v)) || (state_q == ST_DONE && pend_v)) begin
            state_d = src.load_en ? ST_LOAD : (src.count != '0) ? ST_RUN : ST_DONE;
            cnt_d   = src.count[CNT_W-1:0];
            l_d     = src.load_val;
            op_d    = src.op;
        end else if (state_q == ST_LOAD) begin
            state_d = (cnt_q != '0) ? ST_RUN : ST_DONE;
        end else if (state_q == ST_RUN) begin
            // Compare before decrementing so a full-scale count cannot wrap.
            state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_RUN;
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            op_q    <= SEL_HOLD;
            s_q     <= SEL_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            op_q    <= op_d;
            s_q     <= sel_for(state_d, op_d);
            busy_q  <= state_d != ST_IDLE;
            done_q  <= state_d == ST_DONE;
        end
    end

    assign S    = s_q;
    assign L    = l_q;
    assign Busy = busy_q;
    assign Done = done_q;
endmodule
